// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM-subset pipeline: forwarding select encodings,
// the hazard-shadow entry and the register-match helper.
package arm_pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
        logic       we;
        logic       load;
    } stage_ent_t;

    localparam logic [3:0] REG_PC = 4'd15;

    // R15 reads come from the PC path, never from a bypass.
    function automatic logic ent_match(input stage_ent_t e, input logic use_src,
                                       input logic [3:0] src);
        return use_src && (src != REG_PC) && e.valid && e.we && (e.rd == src);
    endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// Forwarding select for one ID-stage read port; flags a load still in EX.
module fwd_port_sel
    import arm_pipe_pkg::*;
(
    input  logic [3:0] src,
    input  logic       use_src,
    input  stage_ent_t ex,
    input  stage_ent_t mem,
    input  stage_ent_t wb,
    output fwd_sel_t   sel,
    output logic       load_hit
);

    logic ex_hit, mem_hit, wb_hit;

    assign ex_hit  = ent_match(ex,  use_src, src);
    assign mem_hit = ent_match(mem, use_src, src);
    assign wb_hit  = ent_match(wb,  use_src, src);

    // A load in EX has no data yet, so the select falls through to older stages.
    assign load_hit = ex_hit & ex.load;

    always_comb begin
        sel = FWD_RF;
        if (ex_hit && !ex.load) sel = FWD_EX;
        else if (mem_hit)       sel = FWD_MEM;
        else if (wb_hit)        sel = FWD_WB;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: shadows rd through EX/MEM/WB, drives operand
// bypass selects, load-use stalls, branch flush and a saturating stall counter.
module pipe_hazard_ctrl
    import arm_pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       id_rn,
    input  logic [3:0]       id_rm,
    input  logic [3:0]       id_rd,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             id_use_rd,
    input  logic             id_rf_we,
    input  logic             id_load,
    input  logic             id_branch,
    input  logic             id_cond,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       fwd_c,
    output logic             pc_ld_n,
    output logic             ifid_ld_n,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_ent_t ex_q, mem_q, wb_q, ex_d;
    fwd_sel_t   sel_a, sel_b, sel_c;
    logic       hit_a, hit_b, hit_c;
    logic       hazard;

    fwd_port_sel u_port_a (.src(id_rn), .use_src(id_use_rn), .ex(ex_q), .mem(mem_q),
                           .wb(wb_q), .sel(sel_a), .load_hit(hit_a));
    fwd_port_sel u_port_b (.src(id_rm), .use_src(id_use_rm), .ex(ex_q), .mem(mem_q),
                           .wb(wb_q), .sel(sel_b), .load_hit(hit_b));
    fwd_port_sel u_port_c (.src(id_rd), .use_src(id_use_rd), .ex(ex_q), .mem(mem_q),
                           .wb(wb_q), .sel(sel_c), .load_hit(hit_c));

    assign hazard      = rst_n & (hit_a | hit_b | hit_c);
    assign fwd_a       = sel_a;
    assign fwd_b       = sel_b;
    assign fwd_c       = sel_c;
    assign pc_ld_n     = hazard;
    assign ifid_ld_n   = hazard;
    assign idex_bubble = hazard;
    // A stalled branch stays in ID and flushes once the stall clears.
    assign ifid_flush  = rst_n & id_branch & id_cond & ~hazard;

    always_comb begin
        ex_d = '0;
        if (!hazard) begin
            ex_d.valid = 1'b1;
            ex_d.rd    = id_rd;
            ex_d.we    = id_rf_we & id_cond;
            ex_d.load  = id_load & id_cond;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            stall_cnt <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (hazard && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a narrow-counter instance covers saturation.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  id_rn, id_rm, id_rd;
    logic        id_use_rn, id_use_rm, id_use_rd;
    logic        id_rf_we, id_load, id_branch, id_cond;
    logic [1:0]  fwd_a, fwd_b, fwd_c;
    logic        pc_ld_n, ifid_ld_n, idex_bubble, ifid_flush;
    logic [15:0] stall_cnt;
    logic [1:0]  s_fwd_a, s_fwd_b, s_fwd_c;
    logic        s_pc_ld_n, s_ifid_ld_n, s_idex_bubble, s_ifid_flush;
    logic [1:0]  s_stall_cnt;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
        .id_rf_we(id_rf_we), .id_load(id_load), .id_branch(id_branch), .id_cond(id_cond),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c),
        .pc_ld_n(pc_ld_n), .ifid_ld_n(ifid_ld_n), .idex_bubble(idex_bubble),
        .ifid_flush(ifid_flush), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
        .id_rf_we(id_rf_we), .id_load(id_load), .id_branch(id_branch), .id_cond(id_cond),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .fwd_c(s_fwd_c),
        .pc_ld_n(s_pc_ld_n), .ifid_ld_n(s_ifid_ld_n), .idex_bubble(s_idex_bubble),
        .ifid_flush(s_ifid_flush), .stall_cnt(s_stall_cnt)
    );

    task automatic drive(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                         input logic urn, input logic urm, input logic urd,
                         input logic we, input logic ld, input logic br, input logic cond);
        id_rn = rn; id_rm = rm; id_rd = rd;
        id_use_rn = urn; id_use_rm = urm; id_use_rd = urd;
        id_rf_we = we; id_load = ld; id_branch = br; id_cond = cond;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        drive(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) begin
            nop();
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(4'd4, 4'd4, 4'd4, 1, 1, 1, 1, 1, 0, 1);
        tick();
        tick();
        n_vec++;
        if ({fwd_a, fwd_b, fwd_c} !== 6'b0 || {pc_ld_n, ifid_ld_n, idex_bubble, ifid_flush} !== 4'b0) begin
            $display("FAIL reset_outputs: got fwd=%b%b%b ctl=%b%b%b%b, want all zero",
                     fwd_a, fwd_b, fwd_c, pc_ld_n, ifid_ld_n, idex_bubble, ifid_flush);
            n_err++;
        end
        n_vec++;
        if (stall_cnt !== 16'd0) begin
            $display("FAIL reset_cnt: got %0d, want 0", stall_cnt);
            n_err++;
        end
        rst_n = 1'b1;
        nop();
        tick();
    endtask

    task automatic test_fwd_alu();
        drive(4'd0, 4'd0, 4'd1, 0, 0, 0, 1, 0, 0, 1);   // ADD R1
        tick();
        drive(4'd1, 4'd3, 4'd2, 1, 1, 0, 1, 0, 0, 1);   // SUB R2,R1,R3
        n_vec++;
        if (fwd_a !== 2'b01 || fwd_b !== 2'b00 || idex_bubble !== 1'b0) begin
            $display("FAIL alu_fwd_ex: got a=%b b=%b bub=%b, want a=01 b=00 bub=0", fwd_a, fwd_b, idex_bubble);
            n_err++;
        end
        tick();
        drive(4'd0, 4'd1, 4'd7, 0, 1, 0, 1, 0, 0, 1);   // ORR R7,R0,R1 via rm
        n_vec++;
        if (fwd_b !== 2'b10) begin
            $display("FAIL alu_fwd_mem: got b=%b, want 10", fwd_b);
            n_err++;
        end
        tick();
        drive(4'd1, 4'd0, 4'd8, 1, 0, 0, 1, 0, 0, 1);
        n_vec++;
        if (fwd_a !== 2'b11) begin
            $display("FAIL alu_fwd_wb: got a=%b, want 11", fwd_a);
            n_err++;
        end
        tick();
        drain();
    endtask

    task automatic test_back_to_back();
        drive(4'd0, 4'd0, 4'd6, 0, 0, 0, 1, 0, 0, 1);
        tick();
        drive(4'd0, 4'd0, 4'd6, 0, 0, 0, 1, 0, 0, 1);
        tick();
        drive(4'd6, 4'd6, 4'd0, 1, 1, 0, 0, 0, 0, 1);
        n_vec++;
        if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
            $display("FAIL b2b_youngest: got a=%b b=%b, want 01 01", fwd_a, fwd_b);
            n_err++;
        end
        tick();
        drain();
    endtask

    task automatic test_load_use();
        drive(4'd0, 4'd0, 4'd4, 0, 0, 0, 1, 1, 0, 1);   // LDR R4
        n_vec++;
        if (idex_bubble !== 1'b0 || stall_cnt !== 16'd0) begin
            $display("FAIL ldr_issue: got bub=%b cnt=%0d, want 0 0", idex_bubble, stall_cnt);
            n_err++;
        end
        tick();
        drive(4'd4, 4'd6, 4'd5, 1, 1, 0, 1, 0, 0, 1);   // ADD R5,R4,R6
        n_vec++;
        if ({pc_ld_n, ifid_ld_n, idex_bubble} !== 3'b111 || fwd_a !== 2'b00) begin
            $display("FAIL lu_stall: got ctl=%b%b%b a=%b, want 111 a=00", pc_ld_n, ifid_ld_n, idex_bubble, fwd_a);
            n_err++;
        end
        tick();
        n_vec++;
        if ({pc_ld_n, ifid_ld_n, idex_bubble} !== 3'b000 || fwd_a !== 2'b10 || stall_cnt !== 16'd1) begin
            $display("FAIL lu_resolve: got ctl=%b%b%b a=%b cnt=%0d, want 000 a=10 cnt=1",
                     pc_ld_n, ifid_ld_n, idex_bubble, fwd_a, stall_cnt);
            n_err++;
        end
        tick();
        drain();
    endtask

    task automatic test_store();
        drive(4'd0, 4'd0, 4'd4, 0, 0, 0, 1, 1, 0, 1);   // LDR R4
        tick();
        drive(4'd2, 4'd0, 4'd4, 1, 0, 1, 0, 0, 0, 1);   // STR R4,[R2]
        n_vec++;
        if (idex_bubble !== 1'b1 || fwd_c !== 2'b00) begin
            $display("FAIL st_stall: got bub=%b c=%b, want 1 00", idex_bubble, fwd_c);
            n_err++;
        end
        tick();
        n_vec++;
        if (idex_bubble !== 1'b0 || fwd_c !== 2'b10 || stall_cnt !== 16'd2) begin
            $display("FAIL st_resolve: got bub=%b c=%b cnt=%0d, want 0 10 2", idex_bubble, fwd_c, stall_cnt);
            n_err++;
        end
        tick();
        drain();
    endtask

    task automatic test_branch();
        drive(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1, 1);
        n_vec++;
        if (ifid_flush !== 1'b1) begin
            $display("FAIL br_taken: got flush=%b, want 1", ifid_flush);
            n_err++;
        end
        tick();
        nop();
        n_vec++;
        if (ifid_flush !== 1'b0) begin
            $display("FAIL br_one_cycle: got flush=%b, want 0", ifid_flush);
            n_err++;
        end
        drive(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1, 0);
        n_vec++;
        if (ifid_flush !== 1'b0) begin
            $display("FAIL br_not_taken: got flush=%b, want 0", ifid_flush);
            n_err++;
        end
        tick();
        drive(4'd0, 4'd0, 4'd9, 0, 0, 0, 1, 1, 0, 0);   // LDR R9 with failed condition
        tick();
        drive(4'd9, 4'd9, 4'd9, 1, 1, 1, 0, 0, 0, 1);
        n_vec++;
        if ({fwd_a, fwd_b, fwd_c} !== 6'b0 || idex_bubble !== 1'b0) begin
            $display("FAIL cond_fail_writer: got fwd=%b%b%b bub=%b, want 000000 0", fwd_a, fwd_b, fwd_c, idex_bubble);
            n_err++;
        end
        tick();
        drain();
        drive(4'd0, 4'd0, 4'd4, 0, 0, 0, 1, 1, 0, 1);   // LDR R4
        tick();
        drive(4'd4, 4'd0, 4'd0, 1, 0, 0, 0, 0, 1, 1);   // branch via R4
        n_vec++;
        if (idex_bubble !== 1'b1 || ifid_flush !== 1'b0) begin
            $display("FAIL br_stall_wins: got bub=%b flush=%b, want 1 0", idex_bubble, ifid_flush);
            n_err++;
        end
        tick();
        n_vec++;
        if (idex_bubble !== 1'b0 || ifid_flush !== 1'b1 || fwd_a !== 2'b10 || stall_cnt !== 16'd3) begin
            $display("FAIL br_after_stall: got bub=%b flush=%b a=%b cnt=%0d, want 0 1 10 3",
                     idex_bubble, ifid_flush, fwd_a, stall_cnt);
            n_err++;
        end
        tick();
        drain();
    endtask

    task automatic test_r15();
        drive(4'd0, 4'd0, 4'd15, 0, 0, 0, 1, 0, 0, 1);
        tick();
        drive(4'd15, 4'd15, 4'd15, 1, 1, 1, 0, 0, 0, 1);
        n_vec++;
        if ({fwd_a, fwd_b, fwd_c} !== 6'b0) begin
            $display("FAIL r15_no_fwd: got fwd=%b%b%b, want 000000", fwd_a, fwd_b, fwd_c);
            n_err++;
        end
        tick();
        drain();
    endtask

    task automatic test_reset_mid_stall();
        drive(4'd0, 4'd0, 4'd4, 0, 0, 0, 1, 1, 0, 1);
        tick();
        drive(4'd4, 4'd0, 4'd5, 1, 0, 0, 1, 0, 0, 1);
        n_vec++;
        if (idex_bubble !== 1'b1) begin
            $display("FAIL rst_pre_stall: got bub=%b, want 1", idex_bubble);
            n_err++;
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #2;
        n_vec++;
        if ({pc_ld_n, ifid_ld_n, idex_bubble, ifid_flush} !== 4'b0 || {fwd_a, fwd_b, fwd_c} !== 6'b0
            || stall_cnt !== 16'd0) begin
            $display("FAIL rst_mid_stall: got ctl=%b%b%b%b fwd=%b%b%b cnt=%0d, want zeros",
                     pc_ld_n, ifid_ld_n, idex_bubble, ifid_flush, fwd_a, fwd_b, fwd_c, stall_cnt);
            n_err++;
        end
        tick();
        drain();
    endtask

    task automatic test_saturate();
        for (int unsigned i = 1; i <= 4; i++) begin
            drive(4'd0, 4'd0, 4'd4, 0, 0, 0, 1, 1, 0, 1);
            tick();
            drive(4'd0, 4'd4, 4'd5, 0, 1, 0, 1, 0, 0, 1);
            tick();
            n_vec++;
            if (stall_cnt !== 16'(i) || s_stall_cnt !== ((i > 3) ? 2'd3 : 2'(i))) begin
                $display("FAIL sat_cnt_%0d: got cnt=%0d sat=%0d, want %0d %0d",
                         i, stall_cnt, s_stall_cnt, i, (i > 3) ? 3 : i);
                n_err++;
            end
            tick();
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_fwd_alu();
        test_back_to_back();
        test_load_use();
        test_store();
        test_branch();
        test_r15();
        test_reset_mid_stall();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and forwarding controller for the five-stage ARM-subset pipeline (IF, ID, EX, MEM, WB). It shadows the destination-register flow through EX, MEM and WB, and drives the forwarding muxes for the three ID-stage operand read ports. It stalls PC and IF/ID on load-use hazards and injects bubbles into ID/EX. It flushes IF/ID on taken branches and keeps a saturating stall counter for bring-up.

## Interface
Parameters:
- CNT_W, 16, width of the stall performance counter.

Ports (clock and reset first):
- clk  in  1  pipeline clock; the only clock.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- id_rn, id_rm, id_rd  in  4 each  ID operand register fields: IR[19:16], IR[3:0], IR[15:12].
- id_use_rn, id_use_rm, id_use_rd  in  1 each  operand actually read. use_rd is for store data.
- id_rf_we  in  1  ID instruction writes a register (decoder ID_RF).
- id_load  in  1  ID instruction is a load (decoder ID_load_instr).
- id_branch  in  1  ID instruction is a branch (decoder ID_B).
- id_cond  in  1  condition passed for the ID instruction.
- fwd_a, fwd_b, fwd_c  out  2 each  operand source for Rn, Rm, Rd: 00 RF, 01 EX, 10 MEM, 11 WB.
- pc_ld_n, ifid_ld_n  out  1 each  hold PC / IF-ID register when 1.
- idex_bubble  out  1  force ID/EX control fields to NOP.
- ifid_flush  out  1  load NOP into IF/ID on the next edge.
- stall_cnt  out  CNT_W  count of load-use stall cycles, saturating.

## Operation
- Shadow state: three entries, EX, MEM and WB, each holding {valid, rd[3:0], we, load}.
- Each rising clk when not in reset, the entries shift: WB takes MEM, MEM takes EX, EX takes the ID instruction.
- The ID instruction enters EX as {1, id_rd, id_rf_we & id_cond, id_load & id_cond}.
- When idex_bubble=1, EX instead takes {0, 0, 0, 0}.
- Match rule for a read port: the port is used, the source register is not R15, the entry is valid with we=1, and the entry's rd equals the source register.
- Forward priority per port: EX > MEM > WB > RF.
- Exception: an EX match whose entry has load=1 does not forward. It raises the load-use hazard, and that port's select falls through to MEM/WB/RF.
- Load-use hazard, for any of the three ports:
  - pc_ld_n=1, ifid_ld_n=1 and idex_bubble=1 for exactly one cycle.
  - The next cycle the load is in MEM and the select resolves to 10.
- Taken branch (id_branch & id_cond with no hazard): ifid_flush=1 for one cycle.
- Stall and branch in the same cycle: the stall wins and ifid_flush is held to 0. The branch stays in ID and is re-evaluated the next cycle.
- stall_cnt increments on each cycle with idex_bubble=1 caused by a hazard. It holds at all-ones.
- id_cond=0 makes the ID instruction a non-writer: it cannot create a hazard downstream.

## Timing
- fwd_*, pc_ld_n, ifid_ld_n, idex_bubble and ifid_flush are combinational from the shadow state and the current ID inputs, valid within the same cycle.
- Shadow entries and stall_cnt are registered, updated on rising clk.
- Load-use penalty is exactly one cycle. Branch penalty is exactly one flushed slot.
- Reset (rst_n=0 at an edge):
  - All entries are cleared to invalid and stall_cnt is cleared to 0.
  - Outputs therefore read fwd_*=00, pc_ld_n=0, ifid_ld_n=0, idex_bubble=0, ifid_flush=0.
  - The ID inputs are ignored while rst_n=0.
- Reset mid-stall: the stall drops on the cycle after reset is sampled, and no stale forwarding survives.
- Back-to-back writers to the same rd resolve to the youngest stage.

## Structure
- Shared package arm_pipe_pkg holds:
  - the fwd_sel_t encodings FWD_RF, FWD_EX, FWD_MEM and FWD_WB;
  - the shadow entry struct stage_ent_t;
  - the constant REG_PC = 4'd15.
- Sub-module fwd_port_sel performs one port's match and priority. It takes src, use and the three entries, and outputs sel and load_hit. It is instantiated three times.

## Test plan
- ADD R1 then SUB R2,R1,R3 back-to-back: fwd_a=01, no stall. One instruction later fwd_a=10; two later fwd_a=11.
- LDR R4 then ADD R5,R4,R6: one cycle with pc_ld_n=ifid_ld_n=idex_bubble=1 and stall_cnt 0->1. The next cycle fwd_a=10.
- STR with Rd=R4 right after LDR R4: the stall is triggered via use_rd, then fwd_c=10.
- Taken branch (id_branch=1, id_cond=1): ifid_flush=1 for exactly one cycle. With id_cond=0: no flush and no forwarding from that slot.
- A read port sourcing R15 while a writer with rd=15 is in EX: select stays 00.
- rst_n=0 during a load-use stall: next-cycle outputs all 0/00 and stall_cnt=0. Force stall_cnt to all-ones, then stall: it stays all-ones.
